// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared codes, lamp constants and default limits for the traffic timing front end
package traffic_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } ctrl_state_t;

  localparam logic [3:0] LAMP_MG = 4'b1000;
  localparam logic [3:0] LAMP_MY = 4'b0100;
  localparam logic [3:0] LAMP_SG = 4'b0010;
  localparam logic [3:0] LAMP_SY = 4'b0001;

  localparam int DEFAULT_SHORT_LIMIT = 5;
  localparam int DEFAULT_LONG_LIMIT  = 20;

  // Encoded so that the state bits read as {TS,TL}
  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    SHORT_DONE = 2'b10,
    LONG_DONE  = 2'b11
  } cnt_state_t;

  function automatic logic lamp_legal(input logic [3:0] lamps);
    return (lamps == 4'b0000) || (lamps == LAMP_MG) || (lamps == LAMP_MY) ||
           (lamps == LAMP_SG) || (lamps == LAMP_SY);
  endfunction

endpackage

// File: rtl/car_sensor_debounce.sv
// rtl/car_sensor_debounce.sv - two-flop synchroniser plus run-length debounce for the side-road detector
module car_sensor_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic car_raw,
  output logic car
);

  localparam int             RW       = $clog2(DEBOUNCE + 1);
  localparam logic [RW-1:0]  RUN_LAST = RW'(DEBOUNCE - 1);

  logic          s1;
  logic          s;
  logic [RW-1:0] run;

  // run counts consecutive samples disagreeing with car; any agreeing sample restarts it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1  <= 1'b0;
      s   <= 1'b0;
      run <= '0;
      car <= 1'b0;
    end else begin
      s1 <= car_raw;
      s  <= s1;
      if (s == car) begin
        run <= '0;
      end else if (run == RUN_LAST) begin
        car <= s;
        run <= '0;
      end else begin
        run <= run + RW'(1);
      end
    end
  end

endmodule

// File: rtl/traffic_timer_unit.sv
// rtl/traffic_timer_unit.sv - interval timer (TS/TL), lamp fault checker and debounced car sense
module traffic_timer_unit
  import traffic_pkg::*;
#(
  parameter int SHORT_LIMIT = DEFAULT_SHORT_LIMIT,
  parameter int LONG_LIMIT  = DEFAULT_LONG_LIMIT,
  parameter int CW          = 32,
  parameter int DEBOUNCE    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ST,
  input  logic MG,
  input  logic MY,
  input  logic SG,
  input  logic SY,
  input  logic car_raw,
  output logic TS,
  output logic TL,
  output logic C,
  output logic lamp_fault
);

  localparam logic [CW-1:0] SHORT_C = CW'(SHORT_LIMIT);
  localparam logic [CW-1:0] LONG_C  = CW'(LONG_LIMIT);

  logic [3:0]    lamps;
  logic [3:0]    lamp_q;
  logic          restart;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  cnt_state_t    state;
  cnt_state_t    state_next;

  assign lamps   = {MG, MY, SG, SY};
  assign restart = ST || (lamps != lamp_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      lamp_q     <= LAMP_MG;
      state      <= IDLE;
      lamp_fault <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      lamp_q <= lamps;
      state  <= state_next;
      if (!lamp_legal(lamps)) lamp_fault <= 1'b1;
    end
  end

  always_comb begin
    cnt_next   = cnt;
    state_next = state;
    if (restart) begin
      cnt_next   = '0;
      state_next = IDLE;
    end else begin
      // Saturate rather than wrap so TL stays asserted until the next restart
      if (cnt < LONG_C) cnt_next = cnt + CW'(1);
      case (state)
        IDLE:       if (cnt_next >= SHORT_C) state_next = SHORT_DONE;
        SHORT_DONE: if (cnt_next >= LONG_C)  state_next = LONG_DONE;
        default:    state_next = state;
      endcase
    end
  end

  assign TS = (cnt >= SHORT_C);
  assign TL = (cnt >= LONG_C);

  car_sensor_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_car_sensor_debounce (
    .clk    (clk),
    .reset  (reset),
    .car_raw(car_raw),
    .car    (C)
  );

endmodule
